sum_display_ctrl: RTL and testbench
===================================

// Module: sum_display_ctrl
// PURPOSE
//  Downstream stage of the 4-bit ripple adder. Captures the 5-bit result {Co,S[3:0]} (0..31)
//  on a load pulse and converts it to two BCD digits with a sequential shift-add-3 engine.
//  Drives a 2-digit multiplexed 7-segment display with leading-zero blanking.
//  Sits between the adder outputs and the board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit stays lit before the scan toggles (>=2)
//  SEG_ACT_LOW  1      1: seg/an active-low (common anode); 0: active-high
// PORTS
//  clk      in   1  system clock, rising edge
//  rst      in   1  synchronous, active-high reset
//  sum_in   in   4  adder sum S[3:0]
//  co_in    in   1  adder carry-out Co (bit 4 of the value)
//  load     in   1  capture request, level-sampled each edge
//  busy     out  1  conversion in progress; load ignored while high
//  done     out  1  one-cycle pulse: new digits latched
//  seg      out  7  segments {g,f,e,d,c,b,a}
//  an       out  2  digit enables: an[0]=units, an[1]=tens
// BEHAVIOUR
//  Reset (rst high at an edge): state=IDLE, busy=0, done=0, value and digit registers=0,
//    refresh counter=0, scan select=units, seg=all off, an=both off for that cycle.
//  First cycle after reset: units digit shows '0', tens blanked.
//  FSM IDLE -> CONV -> IDLE, 2-state, 1 iteration counter (0..4).
//   IDLE: load=1 at edge t -> capture {co_in,sum_in} into shift reg bin[4:0],
//     clear work nibbles, busy=1, state=CONV.
//   CONV: edges t+1..t+5, one iteration each:
//     add 3 to any nibble >=5, then shift {tens,units,bin} left by 1.
//   At edge t+5: latch tens/units display regs, done=1 for exactly one cycle,
//     busy=0, state=IDLE. Total latency load->done = 5 cycles.
//   load high while busy: ignored, not queued. load held high in IDLE: new conversion
//     started every 6 cycles (load re-sampled in the cycle done is high).
//  Display regs change only on done. Display shows the previous value throughout CONV.
//  Arithmetic: tens range 0..3, units 0..9. Tens nibble is 4 bits internally;
//    no overflow is possible for 5-bit input.
//  Scan: refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, scan select toggles.
//    Counter and scan run independently of the FSM and are not disturbed by load or done.
//  Digit select (scan select) -> exactly one an active, seg = decode(digit) on same cycle.
//  Blanking: if tens==0, tens slot drives seg all off (an still active).
//    Units always shown, so 0 -> " 0".
//  Decode: 0..9 standard 7-seg patterns. Codes 10..15 are unreachable and drive all off.
//  Polarity: SEG_ACT_LOW inverts seg and an at the output only.
//  rst mid-conversion: abort immediately, reset values above, no done pulse.
// STRUCTURE
//  Shared package sum_disp_pkg: FSM state enum (IDLE, CONV), 7-seg pattern constants
//    SEG_0..SEG_9 and SEG_BLANK, BCD nibble typedef.
//  One sub-module: bcd_to_7seg (4-bit BCD in -> 7-bit active-high pattern out),
//    combinational. Polarity is applied in the parent.
// TESTING  (REFRESH_DIV=4 in bench)
//  1 rst, then load with co=1 S=4'hF (31) -> done at t+5, busy 1 for t+1..t+5;
//    scan shows tens=3, units=1.
//  2 Load 9 (co=0,S=9) -> tens slot seg all off (7'h7F active-low), units slot = SEG_9.
//  3 Load 16 (co=1,S=0) -> tens=1, units=6. Load 0 -> units '0', tens blank.
//  4 Load 10, then pulse load with 25 at t+2 -> ignored. Display 1,0 after done.
//    Exactly one done pulse.
//  5 Load 20, assert rst at t+3 -> no done, busy=0, display " 0", an off during the rst cycle.
//  6 Scan check: an alternates every 4 cycles, never both active, unaffected by
//    a conversion in flight.

Source files
------------

// File: rtl/sum_disp_pkg.sv
// Shared types and 7-segment patterns for the adder result display.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package sum_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam int NUM_ITER = 5;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/sum_display_ctrl_if.sv
// Load handshake between the ripple adder and the display controller.
// The adder side is the master; the display controller is the slave.
interface sum_display_ctrl_if;

   logic [3:0] sum_in;
   logic       co_in;
   logic       load;
   logic       busy;
   logic       done;

   modport master (
      output sum_in,
      output co_in,
      output load,
      input  busy,
      input  done
   );

   modport slave (
      input  sum_in,
      input  co_in,
      input  load,
      output busy,
      output done
   );

endinterface

// File: rtl/sum_display_ctrl_bcd_to_7seg.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes go dark.
// Output polarity is handled by the parent.
module bcd_to_7seg
   import sum_disp_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sum_display_ctrl.sv
// Captures the 5-bit adder result, converts it to BCD by shift-add-3,
// and scans two multiplexed 7-segment digits with leading-zero blanking.
module sum_display_ctrl
   import sum_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic              clk,
   input  logic              rst,
   sum_display_ctrl_if.slave bus,
   output logic [6:0]        seg,
   output logic [1:0]        an
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [2:0] LAST_ITER = 3'(NUM_ITER - 1);

   state_e          state_q, state_d;
   logic [4:0]      bin_q, bin_d;
   bcd_t            tens_q, tens_d;
   bcd_t            units_q, units_d;
   logic [2:0]      iter_q, iter_d;
   bcd_t            dtens_q, dtens_d;
   bcd_t            dunits_q, dunits_d;
   logic            done_q, done_d;
   logic [CW-1:0]   ref_q, ref_d;
   logic            scan_q, scan_d;
   logic            off_q;

   bcd_t            adj_t, adj_u;
   logic [12:0]     shv;
   bcd_t            digit;
   logic [6:0]      pat;
   logic [6:0]      seg_raw;
   logic [1:0]      an_raw;

   // One shift-add-3 step over {tens,units,bin}
   always_comb begin
      adj_t = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
      adj_u = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
      shv   = {adj_t, adj_u, bin_q} << 1;
   end

   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      tens_d   = tens_q;
      units_d  = units_q;
      iter_d   = iter_q;
      dtens_d  = dtens_q;
      dunits_d = dunits_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               bin_d   = {bus.co_in, bus.sum_in};
               tens_d  = '0;
               units_d = '0;
               iter_d  = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            tens_d  = shv[12:9];
            units_d = shv[8:5];
            bin_d   = shv[4:0];
            iter_d  = iter_q + 3'd1;
            if (iter_q == LAST_ITER) begin
               dtens_d  = shv[12:9];
               dunits_d = shv[8:5];
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ref_d  = ref_q + 1'b1;
      scan_d = scan_q;
      if (ref_q == REF_LAST) begin
         ref_d  = '0;
         scan_d = ~scan_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         tens_q   <= '0;
         units_q  <= '0;
         iter_q   <= '0;
         dtens_q  <= '0;
         dunits_q <= '0;
         done_q   <= 1'b0;
         ref_q    <= '0;
         scan_q   <= 1'b0;
         off_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         tens_q   <= tens_d;
         units_q  <= units_d;
         iter_q   <= iter_d;
         dtens_q  <= dtens_d;
         dunits_q <= dunits_d;
         done_q   <= done_d;
         ref_q    <= ref_d;
         scan_q   <= scan_d;
         off_q    <= 1'b0;
      end
   end

   assign bus.busy = (state_q == CONV);
   assign bus.done = done_q;

   assign digit = scan_q ? dtens_q : dunits_q;

   bcd_to_7seg u_dec (
      .bcd_i (digit),
      .seg_o (pat)
   );

   // Display is dark for the cycle that follows a reset edge
   always_comb begin
      seg_raw = pat;
      an_raw  = scan_q ? 2'b10 : 2'b01;
      if (scan_q && (dtens_q == 4'd0)) seg_raw = SEG_BLANK;
      if (off_q) begin
         seg_raw = SEG_BLANK;
         an_raw  = 2'b00;
      end
   end

   assign seg = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
   assign an  = (SEG_ACT_LOW != 0) ? ~an_raw : an_raw;

endmodule

// File: tb/tb_sum_display_ctrl.sv
// Randomized and directed checks of sum_display_ctrl against a
// cycle-level behavioural model of the load/convert/display rules.
module tb_sum_display_ctrl;

   logic       clk;
   logic       rst;
   logic [6:0] seg;
   logic [1:0] an;

   sum_display_ctrl_if bus ();

   sum_display_ctrl #(
      .REFRESH_DIV (4),
      .SEG_ACT_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .seg (seg),
      .an  (an)
   );

   int tests = 0;
   int fails = 0;

   logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: value, countdown, and edges since reset
   bit mvalid = 0;
   bit m_rstc = 0;
   int m_left = 0;
   int m_val = 0;
   int m_tens = 0;
   int m_units = 0;
   bit m_done = 0;
   int m_cyc = 0;

   always @(posedge clk) begin
      if (rst) begin
         mvalid  = 1;
         m_rstc  = 1;
         m_left  = 0;
         m_tens  = 0;
         m_units = 0;
         m_done  = 0;
         m_cyc   = 0;
      end else begin
         m_rstc = 0;
         m_done = 0;
         m_cyc++;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_tens  = m_val / 10;
               m_units = m_val % 10;
               m_done  = 1;
            end
         end else if (bus.load) begin
            m_val  = {bus.co_in, bus.sum_in};
            m_left = 5;
         end
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         int sc;
         logic [1:0] ea;
         logic [6:0] es;
         sc = (m_cyc / 4) % 2;
         if (m_rstc) begin
            ea = 2'b11;
            es = 7'h7F;
         end else if (sc == 1) begin
            ea = 2'b01;
            es = (m_tens == 0) ? 7'h7F : ~PAT[m_tens];
         end else begin
            ea = 2'b10;
            es = ~PAT[m_units];
         end
         chk("m_busy", int'(bus.busy), int'(m_left > 0));
         chk("m_done", int'(bus.done), int'(m_done));
         chk("m_an", int'(an), int'(ea));
         chk("m_seg", int'(seg), int'(es));
      end
   end

   task automatic wait_idle();
      int i = 0;
      while (bus.busy && i < 20) begin
         @(posedge clk); #1;
         i++;
      end
      if (bus.busy) chk("idle_timeout", 0, 1);
   endtask

   task automatic drive(input int v);
      bus.load   = 1'b1;
      bus.sum_in = 4'(v);
      bus.co_in  = 1'(v >> 4);
   endtask

   task automatic do_load(input int v, output int lat, output int bc);
      wait_idle();
      drive(v);
      @(posedge clk); #1;
      bus.load = 1'b0;
      lat = 0;
      bc = int'(bus.busy);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus.done) break;
         bc += int'(bus.busy);
      end
   endtask

   task automatic check_slot(input string nm, input bit tens, input int exp);
      logic [1:0] want;
      want = tens ? 2'b01 : 2'b10;
      for (int i = 0; i < 10; i++) begin
         if (an == want) begin
            chk(nm, int'(seg), exp);
            return;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic count_done(input int n, output int d);
      d = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         d += int'(bus.done);
      end
   endtask

   initial begin
      int lat, bc, dc;
      logic [1:0] hist [16];
      rst = 1'b1;
      bus.load = 1'b0;
      bus.sum_in = 4'd0;
      bus.co_in = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_an", int'(an), 3);
      chk("rst_seg", int'(seg), 'h7F);
      chk("rst_busy", int'(bus.busy), 0);
      @(posedge clk); #1;
      chk("first_an", int'(an), 2);
      chk("first_seg", int'(seg), 'h40);

      do_load(31, lat, bc);
      chk("lat31", lat, 5);
      chk("busy31", bc, 5);
      check_slot("t31_tens", 1, 'h30);
      check_slot("t31_units", 0, 'h79);

      do_load(9, lat, bc);
      chk("lat9", lat, 5);
      check_slot("t9_tens", 1, 'h7F);
      check_slot("t9_units", 0, 'h10);

      do_load(16, lat, bc);
      check_slot("t16_tens", 1, 'h79);
      check_slot("t16_units", 0, 'h02);
      do_load(0, lat, bc);
      check_slot("t0_units", 0, 'h40);
      check_slot("t0_tens", 1, 'h7F);

      wait_idle();
      drive(10);
      @(posedge clk); #1;
      bus.load = 1'b0;
      @(posedge clk); #1;
      drive(25);
      @(posedge clk); #1;
      bus.load = 1'b0;
      count_done(12, dc);
      chk("one_done", dc, 1);
      check_slot("t10_tens", 1, 'h79);
      check_slot("t10_units", 0, 'h40);

      wait_idle();
      drive(20);
      @(posedge clk); #1;
      bus.load = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_an", int'(an), 3);
      chk("abort_seg", int'(seg), 'h7F);
      chk("abort_busy", int'(bus.busy), 0);
      count_done(10, dc);
      chk("abort_nodone", dc, 0);
      check_slot("abort_units", 0, 'h40);
      check_slot("abort_tens", 1, 'h7F);

      wait_idle();
      drive(31);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         bus.load = 1'b0;
         hist[i] = an;
      end
      for (int i = 0; i < 12; i++) begin
         chk("scan_toggle", int'(hist[i+4]), int'({hist[i][0], hist[i][1]}));
         chk("scan_onehot", int'(hist[i][0] ^ hist[i][1]), 1);
      end

      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         rst = ($urandom % 50) == 0;
         bus.load = ($urandom % 3) == 0;
         bus.sum_in = 4'($urandom);
         bus.co_in = 1'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.load = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog at %0t: got timeout expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
